// File: rtl/ysyx_22051145_mem_stage_pkg.sv
// Shared encodings for the memory-access stage: access sizes, FSM states,
// byte-strobe width and the natural-alignment check.
package ysyx_22051145_mem_stage_pkg;

   localparam logic [1:0] MEM_SIZE_B = 2'd0;
   localparam logic [1:0] MEM_SIZE_H = 2'd1;
   localparam logic [1:0] MEM_SIZE_W = 2'd2;
   localparam logic [1:0] MEM_SIZE_D = 2'd3;

   localparam int unsigned BYTE_MASK_W = 8;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StReq  = 2'd1,
      StRsp  = 2'd2
   } state_e;

   // An access is misaligned when the address is not a multiple of its size.
   function automatic logic is_misaligned(input logic [2:0] addr_lo, input logic [1:0] size);
      logic mis;
      case (size)
         MEM_SIZE_B: mis = 1'b0;
         MEM_SIZE_H: mis = addr_lo[0];
         MEM_SIZE_W: mis = |addr_lo[1:0];
         default:    mis = |addr_lo;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/ysyx_22051145_lsu_align.sv
// Byte-lane alignment for the data bus: store data/strobe placement and
// load data extraction with sign or zero extension.
module ysyx_22051145_lsu_align
   import ysyx_22051145_mem_stage_pkg::*;
#(
   parameter int unsigned XLEN = 64
) (
   input  logic [2:0]             i_off,
   input  logic [1:0]             i_size,
   input  logic                   i_uns,
   input  logic [XLEN-1:0]        i_st_data,
   input  logic [XLEN-1:0]        i_ld_data,
   output logic [XLEN-1:0]        o_wdata,
   output logic [BYTE_MASK_W-1:0] o_wmask,
   output logic [XLEN-1:0]        o_ld_result
);

   logic [5:0]             w_shamt;
   logic [BYTE_MASK_W-1:0] w_size_mask;
   logic [XLEN-1:0]        w_ld_shift;

   assign w_shamt = {i_off, 3'b000};

   // Store side: move data and strobes up to the addressed byte lane.
   always_comb begin
      w_size_mask = 8'h01;
      case (i_size)
         MEM_SIZE_B: w_size_mask = 8'h01;
         MEM_SIZE_H: w_size_mask = 8'h03;
         MEM_SIZE_W: w_size_mask = 8'h0F;
         default:    w_size_mask = 8'hFF;
      endcase
      o_wmask = w_size_mask << i_off;
      o_wdata = i_st_data << w_shamt;
   end

   // Load side: bring the addressed lane down to bit 0, then extend.
   always_comb begin
      w_ld_shift  = i_ld_data >> w_shamt;
      o_ld_result = w_ld_shift;
      case (i_size)
         MEM_SIZE_B: o_ld_result = {{(XLEN-8){w_ld_shift[7] & ~i_uns}}, w_ld_shift[7:0]};
         MEM_SIZE_H: o_ld_result = {{(XLEN-16){w_ld_shift[15] & ~i_uns}}, w_ld_shift[15:0]};
         MEM_SIZE_W: o_ld_result = {{(XLEN-32){w_ld_shift[31] & ~i_uns}}, w_ld_shift[31:0]};
         default:    o_ld_result = w_ld_shift;
      endcase
   end

endmodule

// File: rtl/ysyx_22051145_mem_stage.sv
// Memory-access stage: accepts one instruction from execute, performs at most
// one outstanding bus load/store, and presents one registered result to writeback.
module ysyx_22051145_mem_stage
   import ysyx_22051145_mem_stage_pkg::*;
#(
   parameter int unsigned XLEN     = 64,
   parameter int unsigned REGIDX_W = 5
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [XLEN-1:0]        in_pc,
   input  logic [XLEN-1:0]        in_exe_dat,
   input  logic [XLEN-1:0]        in_rs2,
   input  logic [REGIDX_W-1:0]    in_rd,
   input  logic                   in_rd_wen,
   input  logic                   in_mem_ld,
   input  logic                   in_mem_st,
   input  logic [1:0]             in_mem_size,
   input  logic                   in_mem_uns,
   output logic                   req_valid,
   input  logic                   req_ready,
   output logic                   req_wen,
   output logic [XLEN-1:0]        req_addr,
   output logic [XLEN-1:0]        req_wdata,
   output logic [BYTE_MASK_W-1:0] req_wmask,
   input  logic                   rsp_valid,
   input  logic [XLEN-1:0]        rsp_rdata,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [XLEN-1:0]        out_pc,
   output logic [REGIDX_W-1:0]    out_rd,
   output logic                   out_rd_wen,
   output logic [XLEN-1:0]        out_dat,
   output logic                   out_misalign
);

   state_e r_state, w_state_nxt;

   // Captured instruction fields, held for the whole bus transaction.
   logic [XLEN-1:0]     r_pc, r_addr, r_rs2;
   logic [REGIDX_W-1:0] r_rd;
   logic                r_rd_wen, r_st, r_uns;
   logic [1:0]          r_size;

   // Writeback output register.
   logic                r_out_valid, r_out_rd_wen, r_out_misalign;
   logic [XLEN-1:0]     r_out_pc, r_out_dat;
   logic [REGIDX_W-1:0] r_out_rd;

   logic                   w_accept, w_is_mem, w_misalign, w_direct, w_rsp_done;
   logic [XLEN-1:0]        w_wdata, w_ld_result;
   logic [BYTE_MASK_W-1:0] w_wmask;

   assign in_ready   = (r_state == StIdle) && (!r_out_valid || out_ready);
   assign w_accept   = in_valid && in_ready;
   assign w_is_mem   = in_mem_ld || in_mem_st;
   assign w_misalign = w_is_mem && is_misaligned(in_exe_dat[2:0], in_mem_size);
   // Non-memory and misaligned ops complete without touching the bus.
   assign w_direct   = w_accept && (!w_is_mem || w_misalign);
   assign w_rsp_done = (r_state == StRsp) && rsp_valid;

   // Both bus directions are aligned from the captured address and size.
   ysyx_22051145_lsu_align #(
      .XLEN(XLEN)
   ) u_lsu_align (
      .i_off      (r_addr[2:0]),
      .i_size     (r_size),
      .i_uns      (r_uns),
      .i_st_data  (r_rs2),
      .i_ld_data  (rsp_rdata),
      .o_wdata    (w_wdata),
      .o_wmask    (w_wmask),
      .o_ld_result(w_ld_result)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic: one bus transaction at a time.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         StIdle: if (w_accept && w_is_mem && !w_misalign) w_state_nxt = StReq;
         StReq:  if (req_ready) w_state_nxt = StRsp;
         StRsp:  if (rsp_valid) w_state_nxt = StIdle;
         default: w_state_nxt = StIdle;
      endcase
   end

   // Bus request outputs, driven only while a request is pending.
   always_comb begin
      req_valid = 1'b0;
      req_wen   = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      req_wmask = '0;
      if (r_state == StReq) begin
         req_valid = 1'b1;
         req_wen   = r_st;
         req_addr  = {r_addr[XLEN-1:3], 3'b000};
         req_wdata = w_wdata;
         req_wmask = w_wmask;
      end
   end

   // Capture instruction fields at every accepted transfer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc     <= '0;
         r_addr   <= '0;
         r_rs2    <= '0;
         r_rd     <= '0;
         r_rd_wen <= 1'b0;
         r_st     <= 1'b0;
         r_uns    <= 1'b0;
         r_size   <= MEM_SIZE_B;
      end else if (w_accept) begin
         r_pc     <= in_pc;
         r_addr   <= in_exe_dat;
         r_rs2    <= in_rs2;
         r_rd     <= in_rd;
         r_rd_wen <= in_rd_wen;
         r_st     <= in_mem_st;
         r_uns    <= in_mem_uns;
         r_size   <= in_mem_size;
      end
   end

   // Output register: load a new result, else clear once consumed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid    <= 1'b0;
         r_out_pc       <= '0;
         r_out_rd       <= '0;
         r_out_rd_wen   <= 1'b0;
         r_out_dat      <= '0;
         r_out_misalign <= 1'b0;
      end else if (w_direct) begin
         r_out_valid    <= 1'b1;
         r_out_pc       <= in_pc;
         r_out_rd       <= in_rd;
         r_out_rd_wen   <= in_rd_wen && !w_misalign;
         r_out_dat      <= in_exe_dat;
         r_out_misalign <= w_misalign;
      end else if (w_rsp_done) begin
         r_out_valid    <= 1'b1;
         r_out_pc       <= r_pc;
         r_out_rd       <= r_rd;
         r_out_rd_wen   <= r_rd_wen && !r_st;
         r_out_dat      <= r_st ? '0 : w_ld_result;
         r_out_misalign <= 1'b0;
      end else if (out_ready) begin
         r_out_valid    <= 1'b0;
         r_out_pc       <= '0;
         r_out_rd       <= '0;
         r_out_rd_wen   <= 1'b0;
         r_out_dat      <= '0;
         r_out_misalign <= 1'b0;
      end
   end

   assign out_valid    = r_out_valid;
   assign out_pc       = r_out_pc;
   assign out_rd       = r_out_rd;
   assign out_rd_wen   = r_out_rd_wen;
   assign out_dat      = r_out_dat;
   assign out_misalign = r_out_misalign;

endmodule
